// File: rtl/rtc_pkg.sv
// Shared types, digit limits and helper functions for the real-time-clock core.
package rtc_pkg;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
        logic [2:0] s1;
        logic [3:0] s0;
    } rtc_time_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } rtc_hm_t;

    typedef struct packed {
        logic      pm;
        rtc_time_t t;
    } rtc_disp_t;

    typedef enum logic {
        SNZ_IDLE,
        SNZ_WAIT
    } snz_state_t;

    localparam int unsigned UNITS_W      = 4;
    localparam int unsigned TENS_W       = 3;
    localparam int unsigned UNITS_MAX    = 9;
    localparam int unsigned TENS_MAX     = 5;
    localparam logic [5:0]  HOUR_MAX_BCD = 6'h23;

    function automatic logic rtc_valid(input rtc_time_t t);
        return (t.s0 <= 4'(UNITS_MAX)) && (t.s1 <= 3'(TENS_MAX)) &&
               (t.m0 <= 4'(UNITS_MAX)) && (t.m1 <= 3'(TENS_MAX)) &&
               (t.h0 <= 4'(UNITS_MAX)) && ({t.h1, t.h0} <= HOUR_MAX_BCD);
    endfunction

    function automatic rtc_disp_t rtc_to_12h(input rtc_time_t t);
        rtc_disp_t  d;
        logic [4:0] h;
        logic [4:0] h12;
        h    = 5'(t.h1) * 5'd10 + 5'(t.h0);
        d.t  = t;
        d.pm = (h >= 5'd12);
        if (h == 5'd0)
            h12 = 5'd12;
        else if (h > 5'd12)
            h12 = h - 5'd12;
        else
            h12 = h;
        if (h12 >= 5'd10) begin
            d.t.h1 = 2'd1;
            d.t.h0 = 4'(h12 - 5'd10);
        end else begin
            d.t.h1 = 2'd0;
            d.t.h0 = h12[3:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_digit.sv
// Single BCD counter digit with synchronous load and combinational carry-out.
module rtc_bcd_digit
    import rtc_pkg::*;
#(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry
);

    assign carry = en && (value == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (en)
            value <= (value == W'(MAX)) ? '0 : value + W'(1);
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// RTC core: prescaler, 24 h BCD time chain, alarm slots and 12/24 h display.
// Optional snooze logic is built when RTC_SNOOZE_EN is defined.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter  int unsigned CLK_DIV    = 2,
    parameter  int unsigned NUM_ALARMS = 4,
    parameter  int unsigned SNOOZE_MIN = 5,
    localparam int unsigned AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_24h,
    input  logic                  set_time,
    input  logic [19:0]           set_value,
    input  logic                  set_alarm,
    input  logic [AW-1:0]         alarm_id,
    input  logic [19:0]           alarm_value,
    input  logic [NUM_ALARMS-1:0] alarm_enable,
    input  logic                  alarm_ack,
    input  logic                  snooze,
    output logic [19:0]           hh_mm_ss,
    output logic                  pm,
    output logic                  sec_pulse,
    output logic [NUM_ALARMS-1:0] alarm_fire,
    output logic                  set_err
);

    localparam int unsigned PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SLOTS_P2 = 1 << AW;

    logic [PW-1:0]         presc;
    logic                  wrap;
    logic                  adv;
    logic                  time_ok;
    logic                  alarm_ok;
    logic                  load;
    rtc_time_t             set_t;
    rtc_time_t             cur;
    rtc_disp_t             d12;
    logic [3:0]            s0, m0, h0, h0_nx;
    logic [2:0]            s1, m1;
    logic [1:0]            h1, h1_nx;
    logic                  s0c, s1c, m0c, m1c;
    rtc_hm_t               hm_next;
    rtc_hm_t               slot [NUM_ALARMS];
    logic [SLOTS_P2-1:0]   id_valid;
    logic [NUM_ALARMS-1:0] fire_set;
    logic [NUM_ALARMS-1:0] rearm;
    logic                  snz_accept;
    logic                  clr_all;
    logic                  unused_bits;

    assign unused_bits = ^alarm_value[6:0];

    assign set_t     = rtc_time_t'(set_value);
    assign time_ok   = rtc_valid(set_t);
    assign load      = set_time && time_ok;
    assign wrap      = (presc == PW'(CLK_DIV - 1));
    assign sec_pulse = wrap;
    assign adv       = wrap && !set_time;

    always_ff @(posedge clk) begin
        if (rst)
            presc <= '0;
        else if (load || wrap)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    rtc_bcd_digit #(.W(UNITS_W), .MAX(UNITS_MAX)) u_s0 (
        .clk(clk), .rst(rst), .en(adv), .load(load),
        .load_val(set_t.s0), .value(s0), .carry(s0c)
    );
    rtc_bcd_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_s1 (
        .clk(clk), .rst(rst), .en(s0c), .load(load),
        .load_val(set_t.s1), .value(s1), .carry(s1c)
    );
    rtc_bcd_digit #(.W(UNITS_W), .MAX(UNITS_MAX)) u_m0 (
        .clk(clk), .rst(rst), .en(s1c), .load(load),
        .load_val(set_t.m0), .value(m0), .carry(m0c)
    );
    rtc_bcd_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_m1 (
        .clk(clk), .rst(rst), .en(m0c), .load(load),
        .load_val(set_t.m1), .value(m1), .carry(m1c)
    );

    // Hours kept as a pair so 23 wraps to 00 rather than 29 -> 30.
    always_comb begin
        h1_nx = h1;
        h0_nx = h0;
        if ({h1, h0} == HOUR_MAX_BCD) begin
            h1_nx = '0;
            h0_nx = '0;
        end else if (h0 == 4'(UNITS_MAX)) begin
            h1_nx = h1 + 2'd1;
            h0_nx = '0;
        end else begin
            h0_nx = h0 + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h1 <= '0;
            h0 <= '0;
        end else if (load) begin
            h1 <= set_t.h1;
            h0 <= set_t.h0;
        end else if (m1c) begin
            h1 <= h1_nx;
            h0 <= h0_nx;
        end
    end

    assign cur = {h1, h0, m1, m0, s1, s0};

    // hh:mm the chain moves to on a minute rollover; only meaningful while s1c.
    always_comb begin
        hm_next.m0 = m0c ? '0 : m0 + 4'd1;
        hm_next.m1 = m0c ? (m1c ? '0 : m1 + 3'd1) : m1;
        hm_next.h1 = m1c ? h1_nx : h1;
        hm_next.h0 = m1c ? h0_nx : h0;
    end

    always_comb begin
        for (int unsigned i = 0; i < SLOTS_P2; i++)
            id_valid[i] = (i < NUM_ALARMS);
    end

    assign alarm_ok = rtc_valid(rtc_time_t'({alarm_value[19:7], 7'd0})) && id_valid[alarm_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++)
                slot[i] <= '0;
        end else if (set_alarm && alarm_ok) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++)
                if (alarm_id == AW'(i))
                    slot[i] <= rtc_hm_t'(alarm_value[19:7]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            set_err <= 1'b0;
        else
            set_err <= (set_time && !time_ok) || (set_alarm && !alarm_ok);
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_ALARMS; i++)
            fire_set[i] = s1c && alarm_enable[i] && (hm_next == slot[i]);
    end

    assign clr_all = alarm_ack || snz_accept;

    always_ff @(posedge clk) begin
        if (rst)
            alarm_fire <= '0;
        else
            alarm_fire <= fire_set | rearm | (alarm_fire & alarm_enable & ~{NUM_ALARMS{clr_all}});
    end

`ifdef RTC_SNOOZE_EN
    localparam int unsigned SNZ_SECS = SNOOZE_MIN * 60;
    localparam int unsigned SCW      = $clog2(SNZ_SECS + 1);

    snz_state_t            snz_state, snz_state_nx;
    logic [SCW-1:0]        snz_cnt, snz_cnt_nx;
    logic [NUM_ALARMS-1:0] snz_mask, snz_mask_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            snz_state <= SNZ_IDLE;
            snz_cnt   <= '0;
            snz_mask  <= '0;
        end else begin
            snz_state <= snz_state_nx;
            snz_cnt   <= snz_cnt_nx;
            snz_mask  <= snz_mask_nx;
        end
    end

    always_comb begin
        snz_state_nx = snz_state;
        snz_cnt_nx   = snz_cnt;
        snz_mask_nx  = snz_mask;
        snz_accept   = 1'b0;
        rearm        = '0;
        if (alarm_ack) begin
            snz_state_nx = SNZ_IDLE;
        end else if (snooze && (|alarm_fire)) begin
            snz_accept   = 1'b1;
            snz_state_nx = SNZ_WAIT;
            snz_cnt_nx   = SCW'(SNZ_SECS);
            snz_mask_nx  = alarm_fire;
        end else if (snz_state == SNZ_WAIT && sec_pulse) begin
            if (snz_cnt == SCW'(1)) begin
                rearm        = snz_mask & alarm_enable;
                snz_state_nx = SNZ_IDLE;
            end
            snz_cnt_nx = snz_cnt - SCW'(1);
        end
    end
`else
    logic unused_snooze;

    assign unused_snooze = snooze;
    assign snz_accept    = 1'b0;
    assign rearm         = '0;
`endif

    assign d12      = rtc_to_12h(cur);
    assign hh_mm_ss = mode_24h ? cur : d12.t;
    assign pm       = mode_24h ? 1'b0 : d12.pm;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: vector table with scoreboard plus
// directed sequences for rollover, alarms, snooze and reset.
module tb_rtc_timekeeper;

    localparam int unsigned NA = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode_24h;
    logic          set_time;
    logic [19:0]   set_value;
    logic          set_alarm;
    logic [2:0]    alarm_id;
    logic [19:0]   alarm_value;
    logic [NA-1:0] alarm_enable;
    logic          alarm_ack;
    logic          snooze;
    logic [19:0]   hh_mm_ss;
    logic          pm;
    logic          sec_pulse;
    logic [NA-1:0] alarm_fire;
    logic          set_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] set_v;
        logic        mode;
        logic [19:0] exp_hms;
        logic        exp_pm;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [19:0] hms;
        logic        pm;
        logic        err;
    } exp_t;

    vec_t vecs [12];
    exp_t exp_q [$];

    rtc_timekeeper #(.CLK_DIV(4), .NUM_ALARMS(NA), .SNOOZE_MIN(1)) dut (
        .clk(clk), .rst(rst), .mode_24h(mode_24h), .set_time(set_time),
        .set_value(set_value), .set_alarm(set_alarm), .alarm_id(alarm_id),
        .alarm_value(alarm_value), .alarm_enable(alarm_enable),
        .alarm_ack(alarm_ack), .snooze(snooze), .hh_mm_ss(hh_mm_ss), .pm(pm),
        .sec_pulse(sec_pulse), .alarm_fire(alarm_fire), .set_err(set_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] t(input int hh, input int mm, input int ss);
        logic [19:0] r;
        r[19:18] = 2'(hh / 10);
        r[17:14] = 4'(hh % 10);
        r[13:11] = 3'(mm / 10);
        r[10:7]  = 4'(mm % 10);
        r[6:4]   = 3'(ss / 10);
        r[3:0]   = 4'(ss % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic load(input logic [19:0] v);
        set_time  = 1'b1;
        set_value = v;
        @(negedge clk);
        set_time  = 1'b0;
    endtask

    task automatic set_alm(input logic [2:0] id, input logic [19:0] v);
        set_alarm   = 1'b1;
        alarm_id    = id;
        alarm_value = v;
        @(negedge clk);
        set_alarm   = 1'b0;
    endtask

    task automatic wait_pulse(input string name);
        int unsigned n = 0;
        while (sec_pulse !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sec_pulse), 32'd1);
    endtask

    task automatic ack();
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
    endtask

    initial begin
        int   pulses;
        logic quiet;
        exp_t e;

        vecs[0]  = '{t(13, 5, 0),  1'b0, t(1, 5, 0),   1'b1, 1'b0};
        vecs[1]  = '{t(0, 30, 0),  1'b0, t(12, 30, 0), 1'b0, 1'b0};
        vecs[2]  = '{t(12, 0, 0),  1'b0, t(12, 0, 0),  1'b1, 1'b0};
        vecs[3]  = '{t(23, 59, 58), 1'b1, t(23, 59, 58), 1'b0, 1'b0};
        vecs[4]  = '{t(24, 0, 0),  1'b1, t(23, 59, 58), 1'b0, 1'b1};
        vecs[5]  = '{t(12, 60, 0), 1'b1, t(23, 59, 58), 1'b0, 1'b1};
        vecs[6]  = '{t(9, 45, 30), 1'b0, t(9, 45, 30), 1'b0, 1'b0};
        vecs[7]  = '{t(23, 15, 7), 1'b0, t(11, 15, 7), 1'b1, 1'b0};
        vecs[8]  = '{t(10, 0, 0),  1'b1, t(10, 0, 0),  1'b0, 1'b0};
        vecs[9]  = '{t(11, 59, 59), 1'b0, t(11, 59, 59), 1'b0, 1'b0};
        vecs[10] = '{t(29, 0, 0),  1'b0, t(11, 59, 59), 1'b0, 1'b1};
        vecs[11] = '{t(20, 0, 0),  1'b0, t(8, 0, 0),   1'b1, 1'b0};

        rst = 1'b1; mode_24h = 1'b1; set_time = 1'b0; set_value = '0;
        set_alarm = 1'b0; alarm_id = '0; alarm_value = '0; alarm_enable = '0;
        alarm_ack = 1'b0; snooze = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_hms", 32'(hh_mm_ss), 32'(t(0, 0, 0)));
        check("rst_fire", 32'(alarm_fire), 32'd0);
        check("rst_pulse", 32'(sec_pulse), 32'd0);
        check("rst_err", 32'(set_err), 32'd0);
        mode_24h = 1'b0;
        #1;
        check("rst_hms_12h", 32'(hh_mm_ss), 32'(t(12, 0, 0)));
        check("rst_pm_12h", 32'(pm), 32'd0);

        // Table: drive a load each cycle, compare one cycle later.
        for (int i = 0; i < 12; i++) begin
            set_time  = 1'b1;
            set_value = vecs[i].set_v;
            mode_24h  = vecs[i].mode;
            exp_q.push_back('{i, vecs[i].exp_hms, vecs[i].exp_pm, vecs[i].exp_err});
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_hms", e.idx), 32'(hh_mm_ss), 32'(e.hms));
            check($sformatf("vec%0d_pm", e.idx), 32'(pm), 32'(e.pm));
            check($sformatf("vec%0d_err", e.idx), 32'(set_err), 32'(e.err));
        end
        set_time = 1'b0;
        mode_24h = 1'b1;

        // Rollover through midnight with CLK_DIV=4.
        load(t(23, 59, 58));
        for (int j = 1; j <= 9; j++) begin
            if (j > 1) @(negedge clk);
            if (j <= 8) check($sformatf("roll_pulse%0d", j), 32'(sec_pulse), 32'((j % 4) == 0));
            if (j == 4) check("roll_hold", 32'(hh_mm_ss), 32'(t(23, 59, 58)));
            if (j == 5) check("roll_59", 32'(hh_mm_ss), 32'(t(23, 59, 59)));
            if (j == 9) check("roll_mid", 32'(hh_mm_ss), 32'(t(0, 0, 0)));
        end

        // set_time on the wrap cycle.
        wait_pulse("wrap_wait");
        set_time  = 1'b1;
        set_value = t(5, 6, 7);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) set_time = 1'b0;
            check($sformatf("wrap_load%0d", k), 32'(hh_mm_ss), (k <= 4) ? 32'(t(5, 6, 7)) : 32'(t(5, 6, 8)));
        end

        // Alarm fire, hold, ack.
        set_alm(3'd0, t(7, 30, 0));
        check("alm_set_err", 32'(set_err), 32'd0);
        alarm_enable = 5'b00001;
        load(t(7, 29, 59));
        wait_pulse("alm_wait");
        check("alm_pre", 32'(alarm_fire), 32'd0);
        @(negedge clk);
        check("alm_fire", 32'(alarm_fire), 32'b00001);
        check("alm_time", 32'(hh_mm_ss), 32'(t(7, 30, 0)));
        repeat (40) @(negedge clk);
        check("alm_hold", 32'(alarm_fire), 32'b00001);
        ack();
        check("alm_ack", 32'(alarm_fire), 32'd0);

        load(t(7, 30, 0));
        check("alm_load_nofire", 32'(alarm_fire), 32'd0);
        wait_pulse("alm_wait2");
        @(negedge clk);
        check("alm_load_nofire2", 32'(alarm_fire), 32'd0);

        load(t(7, 29, 59));
        wait_pulse("alm_wait3");
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
        check("alm_ack_vs_fire", 32'(alarm_fire), 32'b00001);
        alarm_enable = '0;
        @(negedge clk);
        check("alm_en_clear", 32'(alarm_fire), 32'd0);

        set_alm(3'd0, t(25, 0, 0));
        check("alm_bad_val_err", 32'(set_err), 32'd1);
        @(negedge clk);
        check("alm_err_1cyc", 32'(set_err), 32'd0);
        set_alm(3'd5, t(7, 29, 0));
        check("alm_bad_id_err", 32'(set_err), 32'd1);
        alarm_enable = 5'b11111;
        load(t(7, 28, 59));
        wait_pulse("alm_wait4");
        @(negedge clk);
        check("alm_bad_id_nowrite", 32'(alarm_fire), 32'd0);
        alarm_enable = 5'b00001;
        load(t(7, 29, 59));
        wait_pulse("alm_wait5");
        @(negedge clk);
        check("alm_slot_kept", 32'(alarm_fire), 32'b00001);

`ifdef RTC_SNOOZE_EN
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        check("snz_clear", 32'(alarm_fire), 32'd0);
        pulses = 0;
        quiet  = 1'b1;
        for (int c = 0; c < 400 && pulses < 60; c++) begin
            @(negedge clk);
            if (alarm_fire != '0) quiet = 1'b0;
            if (sec_pulse) pulses++;
        end
        check("snz_quiet", 32'(quiet), 32'd1);
        check("snz_pulses", 32'(pulses), 32'd60);
        @(negedge clk);
        check("snz_refire", 32'(alarm_fire), 32'b00001);
        ack();

        load(t(7, 29, 59));
        wait_pulse("snz_wait");
        @(negedge clk);
        check("snz2_fire", 32'(alarm_fire), 32'b00001);
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        repeat (40) @(negedge clk);
        ack();
        quiet = 1'b1;
        for (int c = 0; c < 280; c++) begin
            @(negedge clk);
            if (alarm_fire != '0) quiet = 1'b0;
        end
        check("snz_ack_cancel", 32'(quiet), 32'd1);
`else
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        check("snz_ignored", 32'(alarm_fire), 32'b00001);
        ack();
`endif

        // Reset mid-operation overrides every other input.
        load(t(7, 29, 59));
        wait_pulse("pre_rst_wait");
        @(negedge clk);
        check("pre_rst_fire", 32'(alarm_fire), 32'b00001);
        repeat ($urandom_range(1, 7)) @(negedge clk);
        rst = 1'b1; set_time = 1'b1; set_value = t(5, 5, 5);
        set_alarm = 1'b1; alarm_id = 3'd1; alarm_value = t(7, 0, 0);
        @(negedge clk);
        rst = 1'b0; set_time = 1'b0; set_alarm = 1'b0;
        check("mid_rst_hms", 32'(hh_mm_ss), 32'(t(0, 0, 0)));
        check("mid_rst_fire", 32'(alarm_fire), 32'd0);
        check("mid_rst_pulse", 32'(sec_pulse), 32'd0);
        check("mid_rst_err", 32'(set_err), 32'd0);
        check("mid_rst_pm", 32'(pm), 32'd0);
        alarm_enable = 5'b11111;
        load(t(23, 59, 59));
        wait_pulse("post_rst_wait");
        @(negedge clk);
        check("post_rst_slots", 32'(alarm_fire), 32'b11111);
        check("post_rst_time", 32'(hh_mm_ss), 32'(t(0, 0, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Fully synchronous, parametrised real-time-clock core for the digital clock: a prescaler derives a one-second enable from `clk` and drives a BCD hh:mm:ss counter chain with no ripple clocks. The core keeps time internally in 24 h BCD and presents it in 12 h or 24 h form. It supports time and alarm loading with validity checking, and `NUM_ALARMS` independent alarms with latched fire flags, acknowledge and optional snooze. It sits between the button/set controller and the seven-segment display driver.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per second (≥1).
- `NUM_ALARMS`, default 4: alarm slots (1..16).
- `SNOOZE_MIN`, default 5: snooze length in minutes (1..59).
- `AW` (local): `max(1, $clog2(NUM_ALARMS))`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `mode_24h` in 1: 1 selects 24 h display, 0 selects 12 h display.
- `set_time` in 1: single-cycle strobe that loads `set_value`.
- `set_value` in 20: 24 h BCD time, packed as s0[3:0], s1[6:4], m0[10:7], m1[13:11], h0[17:14], h1[19:18].
- `set_alarm` in 1: single-cycle strobe that loads `alarm_value[19:7]` (hh:mm) into slot `alarm_id`.
- `alarm_id` in AW: target slot for `set_alarm`.
- `alarm_value` in 20: same packing as `set_value`; bits [6:0] are ignored.
- `alarm_enable` in NUM_ALARMS: per-slot enable.
- `alarm_ack` in 1: clears all latched fires and cancels any pending snooze.
- `snooze` in 1: snooze request.
- `hh_mm_ss` out 20: display time, same packing as `set_value`.
- `pm` out 1: PM indicator; 0 whenever `mode_24h`=1.
- `sec_pulse` out 1: one-cycle pulse per second.
- `alarm_fire` out NUM_ALARMS: latched alarm flags.
- `set_err` out 1: one-cycle pulse marking a rejected load.

## Operation
- Prescaler counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0, `sec_pulse`=1 for that cycle, and the time advances on the same edge.
- Counter chain: s0 0–9 → s1 0–5 → m0 0–9 → m1 0–5 → hours 00–23 → 00. Carries propagate within one cycle.
- Validity rule: each digit ≤9; s1 ≤5; m1 ≤5; h1h0 ≤23.
- `set_time` with a valid value: loads the time and clears the prescaler to 0.
- `set_time` with an invalid value: time is unchanged and `set_err` pulses.
- `set_alarm` with an invalid hh:mm, or with `alarm_id` ≥ NUM_ALARMS: ignored, and `set_err` pulses.
- Alarm match condition: time steps by a tick to hh:mm:00 equal to an enabled slot. `alarm_fire[i]` sets on that same edge.
- Loading the time never fires an alarm.
- Fire bits hold until one of:
  - `alarm_ack`;
  - their `alarm_enable` bit is low;
  - snooze accepted.
- A new fire on the same edge as `alarm_ack` wins (set overrides clear).
- Display conversion, 24 h internal → 12 h shown: 00 → 12 AM; 01–11 → AM; 12 → 12 PM; 13–23 → 01–11 PM. In 12 h mode h1 is 0 or 1.
- `hh_mm_ss` and `pm` are combinational from the time registers and `mode_24h`. A mode change is visible in the same cycle.

## Timing
- Reset state:
  - time 00:00:00, prescaler 0;
  - all alarm slots 00:00;
  - `alarm_fire`=0, `sec_pulse`=0, `set_err`=0, snooze idle.
- Display after reset: `hh_mm_ss`=00:00:00 in 24 h mode, 12:00:00 with `pm`=0 in 12 h mode.
- `rst` mid-operation overrides every other input on that edge.
- Priority on a single edge: `rst` > `set_time` > tick. A `set_time` coinciding with a wrap suppresses that increment, though `sec_pulse` still pulses.
- `set_err` is registered: it asserts on the cycle after the strobe, for 1 cycle.
- Latency:
  - loaded time is visible on `hh_mm_ss` the cycle after `set_time`;
  - a fire is visible the cycle after the matching tick edge.

## Configuration
- Macro: `RTC_SNOOZE_EN`.
- Defined:
  - `snooze` is accepted only while any fire is latched;
  - accepting it saves the fire mask, clears `alarm_fire`, and loads a down-counter with SNOOZE_MIN×60;
  - the counter decrements on each `sec_pulse`;
  - when it reaches 0, the saved bits that are still enabled re-assert;
  - `alarm_ack` or `rst` cancels the snooze.
- Undefined: the `snooze` port is present but ignored, and no snooze logic is built.

## Structure
- Shared package `rtc_pkg` holds:
  - `rtc_time_t` packed struct (h1, h0, m1, m0, s1, s0);
  - digit width and limit constants;
  - `rtc_valid()` function;
  - `rtc_to_12h()` function.
- One sub-module, `rtc_bcd_digit`:
  - parameter MAX;
  - inputs enable and load, with a load value;
  - outputs the digit value and a carry-out that is combinational on enable && value==MAX;
  - used for s0, s1, m0, m1.
- Hours are handled as a pair in the parent, because of the 23 → 00 wrap.

## Test plan
- CLK_DIV=4, set 23:59:58: `sec_pulse` every 4 cycles; reads 23:59:59, then 00:00:00, after two pulses.
- `mode_24h`=0: at 13:05:00 shows 01:05:00 with `pm`=1; at 00:30:00 shows 12:30:00 with `pm`=0; at 12:00:00 shows 12:00:00 with `pm`=1.
- Slot 0 set to 07:30 and enabled, time 07:29:59: at the next tick `alarm_fire`=0001; it holds 10 s, then `alarm_ack` clears it. Loading the time 07:30:00 directly does not fire.
- Load 24:00:00, 12:60:00, or `alarm_id`=5 with NUM_ALARMS=4: `set_err` high for 1 cycle; time and slots unchanged.
- With `RTC_SNOOZE_EN` and SNOOZE_MIN=1: fire, then `snooze` → `alarm_fire`=0; it re-asserts exactly on the 60th subsequent `sec_pulse`. A separate run with `alarm_ack` during the snooze → no re-assert.
- `set_time` on the wrap cycle: the loaded value holds for the next CLK_DIV cycles. `rst` at a random cycle → all outputs at reset values the next cycle.
